// File: rtl/metronome_pkg.sv
`default_nettype none
// ============================================================================
// Module   : metronome_pkg
// Brief    : Shared widths, state encodings and period helper for the tempo path.
// Revision : 1.0 - initial release
// ============================================================================
package metronome_pkg;

  localparam int BPM_W = 9;
  localparam int CNT_W = 34;

  typedef enum logic [0:0] {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } beat_state_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } div_state_t;

  // Beat period in clock cycles for a given tempo (floor).
  function automatic logic [CNT_W-1:0] calc_period(input longint unsigned clk_hz,
                                                   input longint unsigned bpm);
    return CNT_W'((clk_hz * 64'd60) / bpm);
  endfunction

endpackage
`default_nettype wire

// File: rtl/period_divider.sv
`default_nettype none
// ============================================================================
// Module   : period_divider
// Brief    : Restoring serial divider, one quotient bit per clock cycle.
// Revision : 1.0 - initial release
// ============================================================================
module period_divider
  import metronome_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             start,
  input  logic [CNT_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] quotient
);

  localparam logic [5:0] c_last_iter = 6'(CNT_W - 1);

  div_state_t       r_state;
  div_state_t       w_state_next;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] r_quo;
  logic [CNT_W-1:0] r_divisor;
  logic [CNT_W-1:0] r_result;
  logic [5:0]       r_iter;
  logic             r_done;

  logic [CNT_W:0]   w_shift;
  logic             w_fits;
  logic [CNT_W-1:0] w_diff;
  logic [CNT_W-1:0] w_rem_next;
  logic [CNT_W-1:0] w_quo_next;
  logic             w_last;

  // The remainder is always below the divisor, so the difference fits in CNT_W bits.
  assign w_shift    = {r_rem, r_quo[CNT_W-1]};
  assign w_fits     = (w_shift >= {1'b0, r_divisor});
  assign w_diff     = w_shift[CNT_W-1:0] - r_divisor;
  assign w_rem_next = w_fits ? w_diff : w_shift[CNT_W-1:0];
  assign w_quo_next = {r_quo[CNT_W-2:0], w_fits};
  assign w_last     = (r_iter == c_last_iter);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_next = BUSY;
      BUSY:    if (w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_result  <= '0;
      r_iter    <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          r_rem     <= '0;
          r_quo     <= dividend;
          r_divisor <= divisor;
          r_iter    <= '0;
        end
      end else begin
        r_rem  <= w_rem_next;
        r_quo  <= w_quo_next;
        r_iter <= r_iter + 6'd1;
        if (w_last) begin
          r_done   <= 1'b1;
          r_result <= w_quo_next;
        end
      end
    end
  end

  assign busy     = (r_state == BUSY);
  assign done     = r_done;
  assign quotient = r_result;

endmodule
`default_nettype wire

// File: rtl/metronome_beat_gen.sv
`default_nettype none
// ============================================================================
// Module   : metronome_beat_gen
// Brief    : Tempo register, period computation and beat pulse / counter.
// Revision : 1.0 - initial release
// ============================================================================
module metronome_beat_gen
  import metronome_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned BPM_MIN     = 30,
  parameter int unsigned BPM_MAX     = 300,
  parameter int unsigned BPM_DEFAULT = 120
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_bpm_up,
  input  logic             i_bpm_down,
  input  logic             i_start_stop,
  output logic             o_trigger,
  output logic [CNT_W-1:0] o_bpm_counter,
  output logic [BPM_W-1:0] o_bpm,
  output logic             o_running
);

  localparam logic [CNT_W-1:0] c_dividend     = CNT_W'(64'(CLK_HZ) * 64'd60);
  localparam logic [CNT_W-1:0] c_reset_period = calc_period(64'(CLK_HZ), 64'(BPM_DEFAULT));
  localparam logic [BPM_W-1:0] c_bpm_min      = BPM_W'(BPM_MIN);
  localparam logic [BPM_W-1:0] c_bpm_max      = BPM_W'(BPM_MAX);
  localparam logic [BPM_W-1:0] c_bpm_default  = BPM_W'(BPM_DEFAULT);

  logic [BPM_W-1:0] r_bpm;
  logic             r_pending;
  logic [CNT_W-1:0] r_next_period;
  logic             r_next_valid;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_count;
  logic             r_trigger;
  beat_state_t      r_state;

  logic             w_up_req;
  logic             w_down_req;
  logic             w_bpm_changed;
  logic [BPM_W-1:0] w_bpm_next;
  logic             w_div_start;
  logic             w_div_busy;
  logic             w_div_done;
  logic [CNT_W-1:0] w_div_quotient;
  logic             w_div_accept;

  beat_state_t      w_state_next;
  logic [CNT_W-1:0] w_count_next;
  logic             w_trigger_next;
  logic             w_wrap;
  logic             w_take_next;

  // Saturated or conflicting requests leave the tempo untouched and start nothing.
  assign w_up_req      = i_bpm_up & ~i_bpm_down & (r_bpm != c_bpm_max);
  assign w_down_req    = i_bpm_down & ~i_bpm_up & (r_bpm != c_bpm_min);
  assign w_bpm_changed = w_up_req | w_down_req;
  assign w_bpm_next    = w_up_req   ? r_bpm + BPM_W'(1) :
                         w_down_req ? r_bpm - BPM_W'(1) : r_bpm;

  assign w_div_start  = r_pending & ~w_div_busy;
  // A quotient that finishes while a newer tempo is pending is stale.
  assign w_div_accept = w_div_done & ~r_pending;

  period_divider u_period_divider (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .start    (w_div_start),
    .dividend (c_dividend),
    .divisor  ({{(CNT_W-BPM_W){1'b0}}, r_bpm}),
    .busy     (w_div_busy),
    .done     (w_div_done),
    .quotient (w_div_quotient)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_bpm     <= c_bpm_default;
      r_pending <= 1'b0;
    end else begin
      r_bpm     <= w_bpm_next;
      r_pending <= w_bpm_changed | (r_pending & ~w_div_start);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= STOPPED;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_count_next   = '0;
    w_trigger_next = 1'b0;
    w_wrap         = 1'b0;
    case (r_state)
      STOPPED: begin
        if (i_start_stop) begin
          w_state_next   = RUNNING;
          w_trigger_next = 1'b1;
        end
      end
      RUNNING: begin
        // A stop request outranks a beat that would fall in the same cycle.
        if (i_start_stop) begin
          w_state_next = STOPPED;
        end else if (r_count == r_period - CNT_W'(1)) begin
          w_wrap         = 1'b1;
          w_trigger_next = 1'b1;
        end else begin
          w_count_next = r_count + CNT_W'(1);
        end
      end
      default: w_state_next = STOPPED;
    endcase
  end

  // New periods land only between beats so each interval is uniform.
  assign w_take_next = r_next_valid & ((r_state == STOPPED) | w_wrap);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_count       <= '0;
      r_trigger     <= 1'b0;
      r_period      <= c_reset_period;
      r_next_period <= '0;
      r_next_valid  <= 1'b0;
    end else begin
      r_count   <= w_count_next;
      r_trigger <= w_trigger_next;
      if (w_take_next) begin
        r_period     <= r_next_period;
        r_next_valid <= 1'b0;
      end
      if (w_div_accept) begin
        r_next_period <= w_div_quotient;
        r_next_valid  <= 1'b1;
      end
    end
  end

  assign o_trigger     = r_trigger;
  assign o_bpm_counter = r_count;
  assign o_bpm         = r_bpm;
  assign o_running     = (r_state == RUNNING);

endmodule
`default_nettype wire

// File: tb/tb_metronome_beat_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_metronome_beat_gen
// Brief    : Self-checking bench with a time-based tempo/beat reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_metronome_beat_gen;

  localparam int CLK_HZ   = 1000;
  localparam int BPM_MIN  = 30;
  localparam int BPM_MAX  = 300;
  localparam int BPM_DEF  = 120;
  localparam int DIV_SPAN = 34;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r_up = 1'b0;
  logic        r_dn = 1'b0;
  logic        r_ss = 1'b0;
  logic        w_trig;
  logic [33:0] w_cnt;
  logic [8:0]  w_bpm;
  logic        w_running;

  int n_checks = 0;
  int n_errors = 0;

  metronome_beat_gen #(
    .CLK_HZ      (CLK_HZ),
    .BPM_MIN     (BPM_MIN),
    .BPM_MAX     (BPM_MAX),
    .BPM_DEFAULT (BPM_DEF)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_bpm_up      (r_up),
    .i_bpm_down    (r_dn),
    .i_start_stop  (r_ss),
    .o_trigger     (w_trig),
    .o_bpm_counter (w_cnt),
    .o_bpm         (w_bpm),
    .o_running     (w_running)
  );

  always #5 clk = ~clk;

  // Reference model: tempo, outstanding division job and beat timing by edge number.
  int edge_no = 0;
  int m_bpm, m_period, m_next, m_fin, m_jbpm, m_last;
  bit m_pend, m_nv, m_run;

  function automatic void model_reset();
    m_bpm    = BPM_DEF;
    m_period = 60 * CLK_HZ / BPM_DEF;
    m_next   = 0;
    m_nv     = 1'b0;
    m_pend   = 1'b0;
    m_fin    = -1000;
    m_jbpm   = BPM_DEF;
    m_run    = 1'b0;
    m_last   = -1000000;
  endfunction

  function automatic void model_step(input bit u, input bit d, input bit s);
    int  x, nb;
    bit  busy, done, accept, start, wrap, take;
    x      = edge_no;
    busy   = (x <= m_fin);
    done   = (x == m_fin + 1);
    accept = done && !m_pend;
    start  = m_pend && !busy;
    nb = m_bpm;
    if (u && !d && m_bpm < BPM_MAX) nb = m_bpm + 1;
    if (d && !u && m_bpm > BPM_MIN) nb = m_bpm - 1;
    wrap = m_run && !s && (x - m_last == m_period);
    take = m_nv && (!m_run || wrap);
    if (take) begin
      m_period = m_next;
      m_nv     = 1'b0;
    end
    if (accept) begin
      m_next = 60 * CLK_HZ / m_jbpm;
      m_nv   = 1'b1;
    end
    if (start) begin
      m_fin  = x + DIV_SPAN;
      m_jbpm = m_bpm;
    end
    m_pend = (nb != m_bpm) || (m_pend && !start);
    m_bpm  = nb;
    if (!m_run) begin
      if (s) begin
        m_run  = 1'b1;
        m_last = x;
      end
    end else if (s) begin
      m_run = 1'b0;
    end else if (wrap) begin
      m_last = x;
    end
  endfunction

  function automatic longint exp_cnt();
    return m_run ? longint'(edge_no - m_last) : 0;
  endfunction

  function automatic longint exp_trig();
    return (m_run && edge_no == m_last) ? 1 : 0;
  endfunction

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  task automatic tick(input bit u, input bit d, input bit s);
    r_up = u;
    r_dn = d;
    r_ss = s;
    @(posedge clk);
    edge_no++;
    if (rst_n) model_step(u, d, s);
    #1;
    check_val("trigger", w_trig, exp_trig());
    check_val("counter", w_cnt, exp_cnt());
    check_val("bpm", w_bpm, m_bpm);
    check_val("running", w_running, m_run);
    r_up = 1'b0;
    r_dn = 1'b0;
    r_ss = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic measure_gap(input string tag, input int exp);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (w_trig) seen = 1'b1;
    end
    if (!seen) begin
      check_val({tag, "_first_timeout"}, 0, 1);
    end else begin
      seen = 1'b0;
      for (int i = 1; i <= 3000 && !seen; i++) begin
        tick(1'b0, 1'b0, 1'b0);
        if (w_trig) begin
          seen = 1'b1;
          check_val(tag, i, exp);
        end
      end
      if (!seen) check_val({tag, "_timeout"}, 0, 1);
    end
  endtask

  initial begin
    bit found;
    int r;
    model_reset();
    idle(3);
    rst_n = 1'b1;
    idle(5);

    // First beat right after start, then steady 500-cycle beats.
    tick(1'b0, 1'b0, 1'b1);
    check_val("first_trigger", w_trig, 1);
    measure_gap("gap_120", 500);
    measure_gap("gap_120b", 500);

    for (int i = 0; i < 60; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
    end
    check_val("bpm_after_down", w_bpm, 60);
    idle(1500);
    measure_gap("gap_60", 1000);

    for (int i = 0; i < 239; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
    end
    check_val("bpm_299", w_bpm, 299);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
    end
    check_val("bpm_sat_max", w_bpm, 300);
    idle(1200);
    measure_gap("gap_300", 200);

    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0);
    check_val("bpm_conflict", w_bpm, 300);
    measure_gap("gap_conflict", 200);

    // Back to 120 BPM, then stop exactly on the cycle a beat would fire.
    for (int i = 0; i < 180; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
    end
    idle(800);
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      if (m_run && m_period == 500 && exp_cnt() == 499) found = 1'b1;
      else tick(1'b0, 1'b0, 1'b0);
    end
    check_val("stop_window_found", found, 1);
    check_val("cnt_before_stop", w_cnt, 499);
    tick(1'b0, 1'b0, 1'b1);
    check_val("stop_no_trigger", w_trig, 0);
    check_val("stop_running", w_running, 0);
    idle(20);
    check_val("stop_cnt_held", w_cnt, 0);

    // Reset in the middle of a division toward 200 BPM.
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 80; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
    end
    idle(10);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("rst_bpm", w_bpm, BPM_DEF);
    check_val("rst_running", w_running, 0);
    check_val("rst_trigger", w_trig, 0);
    check_val("rst_counter", w_cnt, 0);
    tick(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(60);
    tick(1'b0, 1'b0, 1'b1);
    measure_gap("gap_after_rst", 500);
    measure_gap("gap_after_rst_b", 500);

    // Random pulse traffic against the model.
    for (int i = 0; i < 5000; i++) begin
      r = $urandom_range(0, 199);
      if (r < 4)       tick(1'b1, 1'b0, 1'b0);
      else if (r < 8)  tick(1'b0, 1'b1, 1'b0);
      else if (r == 8) tick(1'b1, 1'b1, 1'b0);
      else if (r == 9) tick(1'b0, 1'b0, 1'b1);
      else             tick(1'b0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
